uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised UART receiver replacing the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count; majority-vote mid-bit sampling; per-frame parity and framing error flags; held-data valid/ack handshake with overrun detection.
- Sits between the async serial pin and the byte consumer (transmitter loopback or host logic).

Parameters:
- CLK_PER_BIT, 5208, clock cycles per bit (50 MHz / 9600); legal range ≥ 8.
- DATA_BITS, 8, data bits per frame; legal 5..9; LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked: 1 or 2.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_bit  in  1  async serial line; idle high.
- i_rx_ack  in  1  consumer accepts held frame; sampled only while o_rx_valid=1.
- o_rx_data  out  DATA_BITS  received data, bit 0 = first data bit received.
- o_rx_valid  out  1  frame held; high until acked.
- o_parity_err  out  1  parity mismatch on held frame; 0 when PARITY=0.
- o_frame_err  out  1  any checked stop bit sampled 0 on held frame.
- o_overrun  out  1  previous unacked frame was overwritten by this one.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FSM → IDLE; all outputs 0.
  - 2-flop synchroniser and 3-sample history preset to 1.
  - A partial frame in progress is discarded.
- Input path:
  - i_rx_bit passes through a 2-flop synchroniser (2-cycle latency).
  - The "sample" value = majority of the last 3 synchronised values.
- Counters:
  - Baud counter width $clog2(CLK_PER_BIT); counts 0..CLK_PER_BIT-1, then wraps to 0.
  - Bit counter width $clog2(DATA_BITS+1).
- IDLE: on synchronised value 0 → START, baud counter cleared.
- START: when counter = (CLK_PER_BIT-1)/2, take the sample:
  - 0 → DATA, counter cleared.
  - 1 → false start: IDLE; no output; no flags.
- DATA:
  - When counter = CLK_PER_BIT-1, sample into the shift register at index bit_count.
  - After DATA_BITS samples: → PARITY if PARITY≠0, else → STOP.
- PARITY:
  - Sample the parity bit at full-bit boundary.
  - Error if XOR(data, parity bit) ≠ 1 for odd, or ≠ 0 for even.
- STOP:
  - Sample each stop bit at full-bit boundary; any 0 sets the frame error.
  - After the last stop sample → DONE.
- DONE (1 cycle): commit data and flags to the output registers.
  - Next state is IDLE if the synchronised line is 1.
  - Otherwise BREAK_WAIT (stop bit low / break).
- BREAK_WAIT: remain until the synchronised line is 1, then → IDLE. A held-low line never produces repeated frames.
- Latency: o_rx_valid rises the cycle after DONE, i.e. 1 cycle after the mid-point sample of the final stop bit. The receiver is rearmed half a bit early for back-to-back frames.
- Handshake:
  - o_rx_valid, o_rx_data and flags are stable while valid=1.
  - i_rx_ack=1 with valid=1 clears valid and all flags next cycle; data register retains its value.
  - Ack while valid=0 is ignored.
- Commit while valid=0: load data and flags; valid←1; o_overrun←0.
- Commit while valid=1 and no ack: overwrite data and flags; o_overrun←1; valid stays 1.
- Commit and ack in the same cycle: new frame loaded; valid stays 1; o_overrun←0.
- o_busy=1 in every state except IDLE.
- Errors never suppress delivery; a frame with errors is presented with its flags set.

Test Plan (CLK_PER_BIT=16):
1. Defaults DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5 → o_rx_valid=1, o_rx_data=0xA5, all flags 0. Hold for 100 cycles without ack → stays; pulse i_rx_ack → valid=0 next cycle.
2. Glitch: line low for 3 cycles then high → no valid, FSM back to IDLE, o_busy=0 within 12 cycles. Single-cycle low spike mid-data-bit of 0x3C → data still 0x3C (majority vote).
3. PARITY=2, DATA_BITS=7: send 0x41 with parity bit 0 → parity_err=0. Send 0x41 with parity bit 1 → parity_err=1, data=0x41.
4. STOP_BITS=2: second stop bit driven 0 → frame_err=1. Line held low 40 bit-times → exactly one frame (data=0x00, frame_err=1), no further valid until the line returns high.
5. Send two frames 0x11, 0x22 with no ack → data=0x22, o_overrun=1. Repeat with ack asserted in the commit cycle of the second frame → valid stays 1, data=0x22, o_overrun=0.
6. Assert i_reset during data bit 4 of 0xFF → all outputs 0 immediately. After release, a fresh 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority vote,
// parity/framing checks and a held-frame valid/ack handshake with overrun flag.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx_bit,
  input  logic                 i_rx_ack,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_HALF      = CW'((CLK_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] C_FULL      = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] C_LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          C_LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5,
    S_BREAK  = 3'd6
  } state_t;

  function automatic logic parity_err(input logic [DATA_BITS-1:0] data, input logic pbit);
    logic x;
    x = ^{data, pbit};
    if (PARITY == 1) return ~x;
    else if (PARITY == 2) return x;
    else return 1'b0;
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [2:0]           r_hist;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_sample;

  assign w_sample = majority3(r_hist);

  // Line synchroniser and sample history; idle-high preset avoids a false start after reset
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
    end else begin
      r_sync1 <= i_rx_bit;
      r_sync2 <= r_sync1;
      r_hist  <= {r_hist[1:0], r_sync2};
    end
  end

  // Frame FSM: baud timing, bit capture and per-frame error accumulation
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_sync2) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (w_sample) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt <= '0;
            for (int i = 0; i < DATA_BITS; i++) begin
              if (r_bit_cnt == BW'(i)) r_shift[i] <= w_sample;
            end
            if (r_bit_cnt == C_LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_perr  <= parity_err(r_shift, w_sample);
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_FULL) begin
            r_cnt <= '0;
            if (!w_sample) r_ferr <= 1'b1;
            if (r_stop_cnt == C_LAST_STOP) r_state <= S_DONE;
            else r_stop_cnt <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // A still-low line means break; wait for idle so it cannot retrigger
          if (r_sync2) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (r_sync2) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Held-frame output registers with valid/ack handshake and overrun detection
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_rx_data    <= r_shift;
      r_rx_valid   <= 1'b1;
      r_parity_err <= r_perr;
      r_frame_err  <= r_ferr;
      r_overrun    <= r_rx_valid & ~i_rx_ack;
    end else if (r_rx_valid && i_rx_ack) begin
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances cover 8N1, 7E1 and 8N2 framing.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] ack;

  logic [7:0] d0;
  logic       v0, p0, f0, o0, b0;
  logic [6:0] d1;
  logic       v1, p1, f1, o1, b1;
  logic [7:0] d2;
  logic       v2, p2, f2, o2, b2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_rx0 (
    .i_clock(clk), .i_reset(rst), .i_rx_bit(rx[0]), .i_rx_ack(ack[0]),
    .o_rx_data(d0), .o_rx_valid(v0), .o_parity_err(p0), .o_frame_err(f0),
    .o_overrun(o0), .o_busy(b0));

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_rx1 (
    .i_clock(clk), .i_reset(rst), .i_rx_bit(rx[1]), .i_rx_ack(ack[1]),
    .o_rx_data(d1), .o_rx_valid(v1), .o_parity_err(p1), .o_frame_err(f1),
    .o_overrun(o1), .o_busy(b1));

  uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_rx2 (
    .i_clock(clk), .i_reset(rst), .i_rx_bit(rx[2]), .i_rx_ack(ack[2]),
    .o_rx_data(d2), .o_rx_valid(v2), .o_parity_err(p2), .o_frame_err(f2),
    .o_overrun(o2), .o_busy(b2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // bits[0] is the start bit; one line cycle may be forced low (spike) and one ack cycle raised
  task automatic send_line(input int idx, input logic [31:0] bits, input int n,
                           input int spike_at, input int ack_at);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rx[idx]  = ((i * CPB + c) == spike_at) ? 1'b0 : bits[i];
        ack[idx] = ((i * CPB + c) == ack_at);
      end
    end
  endtask

  task automatic pulse_ack(input int idx);
    @(negedge clk);
    ack[idx] = 1'b1;
    @(negedge clk);
    ack[idx] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 3'b111;
    ack = 3'b000;
    repeat (3) @(negedge clk);
    check("reset valid", 32'(v0), 32'd0);
    check("reset data",  32'(d0), 32'd0);
    check("reset busy",  32'(b0), 32'd0);
    check("reset flags", 32'({p0, f0, o0}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: basic 8N1 frame, hold, ack
    send_line(0, 32'({1'b1, 8'hA5, 1'b0}), 10, -1, -1);
    check("t1 valid", 32'(v0), 32'd1);
    check("t1 data",  32'(d0), 32'hA5);
    check("t1 flags", 32'({p0, f0, o0}), 32'd0);
    check("t1 busy",  32'(b0), 32'd0);
    repeat (100) @(negedge clk);
    check("t1 hold valid", 32'(v0), 32'd1);
    check("t1 hold data",  32'(d0), 32'hA5);
    pulse_ack(0);
    check("t1 ack valid", 32'(v0), 32'd0);
    check("t1 ack data kept", 32'(d0), 32'hA5);

    // 2: short glitch is a false start; single-cycle spike is voted out
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx[0] = 1'b0;
    end
    @(negedge clk);
    rx[0] = 1'b1;
    check("t2 glitch busy", 32'(b0), 32'd1);
    repeat (12) @(negedge clk);
    check("t2 glitch idle",  32'(b0), 32'd0);
    check("t2 glitch valid", 32'(v0), 32'd0);
    send_line(0, 32'({1'b1, 8'h3C, 1'b0}), 10, 3 * CPB + 6, -1);
    check("t2 spike valid", 32'(v0), 32'd1);
    check("t2 spike data",  32'(d0), 32'h3C);
    pulse_ack(0);

    // 3: 7E1 parity good and bad
    send_line(1, 32'({1'b1, 1'b0, 7'h41, 1'b0}), 10, -1, -1);
    check("t3 good valid", 32'(v1), 32'd1);
    check("t3 good data",  32'(d1), 32'h41);
    check("t3 good perr",  32'(p1), 32'd0);
    pulse_ack(1);
    send_line(1, 32'({1'b1, 1'b1, 7'h41, 1'b0}), 10, -1, -1);
    check("t3 bad valid", 32'(v1), 32'd1);
    check("t3 bad data",  32'(d1), 32'h41);
    check("t3 bad perr",  32'(p1), 32'd1);
    check("t3 bad ferr",  32'(f1), 32'd0);
    pulse_ack(1);
    check("t3 ack perr", 32'(p1), 32'd0);

    // 4: second stop bit low, then a long break
    send_line(2, 32'({1'b0, 1'b1, 8'h96, 1'b0}), 11, -1, -1);
    rx[2] = 1'b1;
    check("t4 stop valid", 32'(v2), 32'd1);
    check("t4 stop data",  32'(d2), 32'h96);
    check("t4 stop ferr",  32'(f2), 32'd1);
    repeat (10) @(negedge clk);
    check("t4 stop idle", 32'(b2), 32'd0);
    pulse_ack(2);
    @(negedge clk);
    rx[2] = 1'b0;
    repeat (400) @(negedge clk);
    check("t4 break valid",   32'(v2), 32'd1);
    check("t4 break data",    32'(d2), 32'h00);
    check("t4 break ferr",    32'(f2), 32'd1);
    check("t4 break overrun", 32'(o2), 32'd0);
    check("t4 break busy",    32'(b2), 32'd1);
    pulse_ack(2);
    repeat (240) @(negedge clk);
    check("t4 break no refire", 32'(v2), 32'd0);
    check("t4 break wait busy", 32'(b2), 32'd1);
    rx[2] = 1'b1;
    repeat (20) @(negedge clk);
    check("t4 release busy",  32'(b2), 32'd0);
    check("t4 release valid", 32'(v2), 32'd0);

    // 5: overrun, then overlap of ack with the commit cycle
    send_line(0, 32'({1'b1, 8'h11, 1'b0}), 10, -1, -1);
    send_line(0, 32'({1'b1, 8'h22, 1'b0}), 10, -1, -1);
    check("t5 ovr valid",   32'(v0), 32'd1);
    check("t5 ovr data",    32'(d0), 32'h22);
    check("t5 ovr overrun", 32'(o0), 32'd1);
    pulse_ack(0);
    check("t5 ack overrun", 32'(o0), 32'd0);
    send_line(0, 32'({1'b1, 8'h11, 1'b0}), 10, -1, -1);
    send_line(0, 32'({1'b1, 8'h22, 1'b0}), 10, -1, 9 * CPB + 11);
    check("t5 same valid",   32'(v0), 32'd1);
    check("t5 same data",    32'(d0), 32'h22);
    check("t5 same overrun", 32'(o0), 32'd0);

    // 6: reset during data bit 4 with a frame still held
    send_line(0, 32'({1'b1, 8'hFF, 1'b0}), 5, -1, -1);
    repeat (8) @(negedge clk);
    check("t6 pre busy", 32'(b0), 32'd1);
    rst   = 1'b1;
    rx[0] = 1'b1;
    #1;
    check("t6 rst valid", 32'(v0), 32'd0);
    check("t6 rst data",  32'(d0), 32'd0);
    check("t6 rst busy",  32'(b0), 32'd0);
    check("t6 rst flags", 32'({p0, f0, o0}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_line(0, 32'({1'b1, 8'h5A, 1'b0}), 10, -1, -1);
    check("t6 new valid", 32'(v0), 32'd1);
    check("t6 new data",  32'(d0), 32'h5A);
    check("t6 new flags", 32'({p0, f0, o0}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
